// File: rtl/ats_cmd_rx_pkg.sv
// Shared types for the ATS command receiver: opcodes, error codes, client states
// and the opcode decode applied when an instruction completes.
package ats_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SET_CLK   = 3'b001,
    OP_TOG_BC    = 3'b010,
    OP_MODE      = 3'b011,
    OP_RSVD      = 3'b100,
    OP_ALARM     = 3'b101,
    OP_COUNTDOWN = 3'b110,
    OP_TOG_AT    = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_RESTART = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    CST_IDLE    = 2'b00,
    CST_COLLECT = 2'b01,
    CST_HOLD    = 2'b10
  } cst_e;

  // NOP and reserved instructions never reach the arbiter.
  function automatic cst_e f_done_state(opcode_e op);
    return (op == OP_NOP || op == OP_RSVD) ? CST_IDLE : CST_HOLD;
  endfunction

  function automatic err_e f_done_err(opcode_e op);
    return (op == OP_RSVD) ? ERR_ILLEGAL : ERR_NONE;
  endfunction

endpackage

// File: rtl/ats_cmd_rx_if.sv
// Client beat buses, output stream and status of the ATS command receiver.
interface ats_cmd_rx_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int BEAT_W      = 16,
  parameter int BEATS       = 2,
  parameter int DEPTH       = 4
);
  localparam int IW = BEATS * BEAT_W;
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int NW = $clog2(DEPTH) + 1;

  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS*BEAT_W-1:0] ctrl;
  logic [NUM_CLIENTS-1:0]        cl_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [IW-1:0]                 out_data;
  logic [CW-1:0]                 out_client;
  logic [2:0]                    out_opcode;
  logic [NUM_CLIENTS-1:0]        err_valid;
  logic [2*NUM_CLIENTS-1:0]      err_code;
  logic [NW-1:0]                 fifo_count;

  modport master (
    output req, ctrl, out_ready,
    input  cl_ready, out_valid, out_data, out_client, out_opcode,
           err_valid, err_code, fifo_count
  );

  modport slave (
    input  req, ctrl, out_ready,
    output cl_ready, out_valid, out_data, out_client, out_opcode,
           err_valid, err_code, fifo_count
  );
endinterface

// File: rtl/ats_cmd_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset, only pointers.
module ats_cmd_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [NW-1:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_cnt == NW'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && o_valid;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/ats_cmd_rx.sv
// Per-client beat deserializers feeding a round-robin arbiter and an output FIFO
// of {instruction, client index}.
module ats_cmd_rx
  import ats_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int BEAT_W      = 16,
  parameter int BEATS       = 2,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  ats_cmd_rx_if.slave bus
);
  localparam int IW = BEATS * BEAT_W;
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int NW = $clog2(DEPTH) + 1;

  cst_e                     r_state [NUM_CLIENTS];
  logic [2:0]               r_cnt   [NUM_CLIENTS];
  opcode_e                  r_op    [NUM_CLIENTS];
  logic [IW-1:0]            r_ins   [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]   r_err_v;
  logic [2*NUM_CLIENTS-1:0] r_err_c;
  logic [CW-1:0]            r_ptr;

  opcode_e                  w_bop   [NUM_CLIENTS];
  logic                     w_gnt_vld;
  logic [CW-1:0]            w_gnt_idx;
  logic                     w_full;
  logic                     w_valid;
  logic [IW+CW-1:0]         w_head;
  logic [NW-1:0]            w_count;
  logic [IW-1:0]            w_data;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_bop[i] = opcode_e'(bus.ctrl[i*BEAT_W + BEAT_W - 3 +: 3]);
    end
  end

  // Round-robin search from r_ptr; nothing is granted while the FIFO is full.
  always_comb begin
    int k;
    k         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!w_full) begin
      for (int j = 0; j < NUM_CLIENTS; j++) begin
        k = (int'(r_ptr) + j) % NUM_CLIENTS;
        if (!w_gnt_vld && r_state[k] == CST_HOLD) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_state[i] <= CST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_err_v <= '0;
      r_err_c <= '0;
      r_ptr   <= '0;
    end else begin
      r_err_v <= '0;
      r_err_c <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        unique case (r_state[i])
          CST_IDLE: begin
            if (bus.req[i]) begin
              if (BEATS == 1) begin
                r_state[i] <= f_done_state(w_bop[i]);
                if (f_done_err(w_bop[i]) != ERR_NONE) begin
                  r_err_v[i]         <= 1'b1;
                  r_err_c[2*i +: 2]  <= f_done_err(w_bop[i]);
                end
              end else begin
                r_state[i] <= CST_COLLECT;
                r_cnt[i]   <= 3'd1;
              end
            end
          end
          CST_COLLECT: begin
            if (bus.req[i]) begin
              r_cnt[i]          <= 3'd1;
              r_err_v[i]        <= 1'b1;
              r_err_c[2*i +: 2] <= ERR_RESTART;
            end else if (r_cnt[i] == 3'(BEATS - 1)) begin
              r_cnt[i]   <= '0;
              r_state[i] <= f_done_state(r_op[i]);
              if (f_done_err(r_op[i]) != ERR_NONE) begin
                r_err_v[i]        <= 1'b1;
                r_err_c[2*i +: 2] <= f_done_err(r_op[i]);
              end
            end else begin
              r_cnt[i] <= r_cnt[i] + 3'd1;
            end
          end
          CST_HOLD: begin
            if (bus.req[i]) begin
              r_err_v[i]        <= 1'b1;
              r_err_c[2*i +: 2] <= ERR_OVERRUN;
            end
            if (w_gnt_vld && w_gnt_idx == CW'(i)) r_state[i] <= CST_IDLE;
          end
          default: r_state[i] <= CST_IDLE;
        endcase
      end
      if (w_gnt_vld) begin
        r_ptr <= (w_gnt_idx == CW'(NUM_CLIENTS - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  // Beat storage; beat 0 lands in the MSBs, later beats fill downward.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (bus.req[i] && r_state[i] != CST_HOLD) begin
        r_ins[i][IW-1 -: BEAT_W] <= bus.ctrl[i*BEAT_W +: BEAT_W];
        r_op[i]                  <= w_bop[i];
      end else if (r_state[i] == CST_COLLECT) begin
        r_ins[i][(BEATS - 1 - int'(r_cnt[i]))*BEAT_W +: BEAT_W] <= bus.ctrl[i*BEAT_W +: BEAT_W];
      end
    end
  end

  ats_cmd_fifo #(
    .DATA_W (IW + CW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_gnt_vld),
    .i_data  ({r_ins[w_gnt_idx], w_gnt_idx}),
    .i_pop   (bus.out_ready),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_data  (w_head),
    .o_count (w_count)
  );

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_rdy
    assign bus.cl_ready[g] = (r_state[g] == CST_IDLE);
  end

  // Head is masked when empty so stale storage never shows after reset.
  assign w_data         = w_valid ? w_head[IW+CW-1:CW] : '0;
  assign bus.out_data   = w_data;
  assign bus.out_client = w_valid ? w_head[CW-1:0] : '0;
  assign bus.out_opcode = w_data[IW-1 -: 3];
  assign bus.out_valid  = w_valid;
  assign bus.err_valid  = r_err_v;
  assign bus.err_code   = r_err_c;
  assign bus.fifo_count = w_count;
endmodule

// File: doc/ats_cmd_rx.md
ATS_CMD_RX -- requirements
Module: ats_cmd_rx

Interface
REQ-001 Parameter NUM_CLIENTS, default 2, number of independent command clients (legal 1..8).
REQ-002 Parameter BEAT_W, default 16, width of one command beat per client.
REQ-003 Parameter BEATS, default 2, beats per instruction (legal 1..4); instruction width IW = BEATS*BEAT_W.
REQ-004 Parameter DEPTH, default 4, output FIFO entries (power of 2, >= 2).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  NUM_CLIENTS  per-client start strobe; high marks beat 0 on ctrl.
REQ-008 ctrl  in  NUM_CLIENTS*BEAT_W  per-client beat bus, client i at [i*BEAT_W +: BEAT_W].
REQ-009 cl_ready  out  NUM_CLIENTS  client i may start a new instruction.
REQ-010 out_valid  out  1  FIFO head holds a valid instruction.
REQ-011 out_ready  in  1  consumer accepts head this cycle.
REQ-012 out_data  out  IW  assembled instruction, beat 0 in MSBs.
REQ-013 out_client  out  max(1,$clog2(NUM_CLIENTS))  originating client index.
REQ-014 out_opcode  out  3  out_data[IW-1:IW-3].
REQ-015 err_valid  out  NUM_CLIENTS  one-cycle error pulse per client.
REQ-016 err_code  out  2*NUM_CLIENTS  per-client error code, valid with err_valid.
REQ-017 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Each client shall run its own FSM: IDLE, COLLECT, HOLD.
REQ-019 IDLE + req[i]: ctrl beat latched same cycle as beat 0; next state COLLECT (HOLD directly if BEATS=1).
REQ-020 COLLECT: one beat latched per cycle irrespective of req, beat counter increments; after beat BEATS-1 latched, go to HOLD.
REQ-021 Opcode decoded on entry to HOLD: 000 (NOP) discarded silently, return IDLE; 100 (reserved) discarded, err code ILLEGAL (2'b01), return IDLE; all others stay HOLD.
REQ-022 req[i] during COLLECT shall abort the partial instruction, latch the new beat 0, restart counter, pulse err code RESTART (2'b10).
REQ-023 req[i] during HOLD shall be ignored with err code OVERRUN (2'b11); held instruction unaffected.
REQ-024 cl_ready[i] shall equal (state==IDLE), driven from registered state only.
REQ-025 Round-robin arbiter shall grant one HOLD client per cycle when fifo_count < DEPTH; search starts at pointer, pointer becomes grantee+1 mod NUM_CLIENTS.
REQ-026 Granted client writes {instruction, index} to FIFO at end of grant cycle and returns IDLE (cl_ready high next cycle).
REQ-027 FIFO full: no grant; HOLD clients wait; no data lost.
REQ-028 Pop occurs when out_valid && out_ready; simultaneous push and pop leaves fifo_count unchanged; push blocked when full even if popping same cycle.
REQ-029 Latency: req at cycle c, FIFO empty, no contention -> out_valid at cycle c+BEATS+1.
REQ-030 out_data/out_client/out_opcode shall be stable while out_valid && !out_ready.
REQ-031 FIFO pointers wrap modulo DEPTH.

Reset
REQ-032 reset shall asynchronously force all FSMs IDLE, beat counters 0, RR pointer 0, FIFO empty.
REQ-033 During and after reset: cl_ready all 1, out_valid 0, out_data 0, out_client 0, err_valid 0, err_code 0, fifo_count 0.
REQ-034 Reset mid-COLLECT or mid-HOLD shall discard the partial/held instruction with no error pulse.

Structure
REQ-035 Package ats_pkg shall hold opcode enum (NOP, SET_CLK, TOG_BC, MODE, RSVD, ALARM, COUNTDOWN, TOG_AT), err-code enum, client-state enum.
REQ-036 FIFO shall be sub-module ats_cmd_fifo (parametrised width/depth, count output); deserializers and arbiter stay in ats_cmd_rx.

Verification
REQ-037 Client 0 beats 16'h2040, 16'h0000, FIFO empty -> out_valid at c+3, out_data 32'h20400000, client 0, opcode 001.
REQ-038 Clients 0 and 1 same cycle, 32'h20400000 and 32'h22000000, pointer 0 -> client 0 out first, client 1 next entry; next tie grants client 0 only if pointer returned to 0.
REQ-039 out_ready=0, DEPTH=4, five alarms 32'hA0800090 -> fifo_count 4, fifth client in HOLD, cl_ready low, req to it -> err OVERRUN; one pop -> fifth pushed.
REQ-040 Beat 0 16'h8000 -> err ILLEGAL pulse, nothing pushed; beat 0 16'h0000 -> no push, no error.
REQ-041 req during COLLECT with new beat 16'hC102 -> err RESTART, only the restarted instruction emerges.
REQ-042 reset asserted mid-COLLECT -> all outputs at reset values immediately, no stale output after release.
